// File: rtl/ext_irq_pkg.sv
// rtl/ext_irq_pkg.sv - shared types and constants for the external interrupt controller
package ext_irq_pkg;

   localparam int IRQ_ID_W    = 4;
   localparam int MAX_SOURCES = 2 ** IRQ_ID_W;

   localparam logic [1:0] ADDR_ENABLE  = 2'd0;
   localparam logic [1:0] ADDR_MODE    = 2'd1;
   localparam logic [1:0] ADDR_PENDING = 2'd2;
   localparam logic [1:0] ADDR_STATUS  = 2'd3;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      REQUEST    = 2'd1,
      IN_SERVICE = 2'd2
   } irq_state_e;

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - per-pin synchroniser with history flop and rising-edge pulse
module irq_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic pin,
   output logic synced,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign synced = sync_q[SYNC_STAGES-1];
   assign rise   = synced & ~hist_q;

endmodule

// File: rtl/ext_irq_controller.sv
// rtl/ext_irq_controller.sv - external interrupt pending/priority logic with claim/complete handshake
module ext_irq_controller
   import ext_irq_pkg::*;
#(
   parameter int NUM_SOURCES = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_SOURCES-1:0] int_ext,
   input  logic                   reg_we,
   input  logic [1:0]             reg_addr,
   input  logic [31:0]            reg_wdata,
   output logic [31:0]            reg_rdata,
   output logic                   irq,
   output logic [IRQ_ID_W-1:0]    irq_id,
   input  logic                   irq_claim,
   input  logic                   irq_complete
);

   logic [NUM_SOURCES-1:0] synced, rise;
   logic [NUM_SOURCES-1:0] en_q, mode_q, pend_q, pend_d;
   logic [NUM_SOURCES-1:0] req, w1c_mask, claim_mask, clr_mask;
   logic [MAX_SOURCES-1:0] req_wide, claim_wide;
   logic [IRQ_ID_W-1:0]    win_id, irq_id_q, id_d;
   logic                   any_req, irq_q, claim_take;
   irq_state_e             state_q, state_d;

   for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_sync
      irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk    (clk),
         .reset  (reset),
         .pin    (int_ext[g]),
         .synced (synced[g]),
         .rise   (rise[g])
      );
   end

   assign req      = pend_q & en_q;
   assign req_wide = MAX_SOURCES'(req);
   assign any_req  = |req;

   // Lowest index wins: scan downwards so the last hit is the smallest.
   always_comb begin
      win_id = '0;
      for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
         if (req[i]) win_id = IRQ_ID_W'(i);
      end
   end

   assign claim_take = (state_q == REQUEST) && irq_claim;
   assign claim_wide = claim_take ? (MAX_SOURCES'(1) << irq_id_q) : '0;
   assign claim_mask = claim_wide[NUM_SOURCES-1:0];
   assign w1c_mask   = (reg_we && reg_addr == ADDR_PENDING) ? reg_wdata[NUM_SOURCES-1:0] : '0;
   assign clr_mask   = claim_mask | w1c_mask;

   // A fresh edge beats any clear landing on the same bit; level sources just mirror the pin.
   always_comb begin
      pend_d = '0;
      for (int i = 0; i < NUM_SOURCES; i++) begin
         if (mode_q[i]) pend_d[i] = (rise[i] & en_q[i]) | (pend_q[i] & ~clr_mask[i]);
         else           pend_d[i] = synced[i] & en_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         en_q   <= '0;
         mode_q <= '0;
         pend_q <= '0;
      end else begin
         if (reg_we && reg_addr == ADDR_ENABLE) en_q   <= reg_wdata[NUM_SOURCES-1:0];
         if (reg_we && reg_addr == ADDR_MODE)   mode_q <= reg_wdata[NUM_SOURCES-1:0];
         pend_q <= pend_d;
      end
   end

   always_comb begin
      state_d = state_q;
      id_d    = irq_id_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d = REQUEST;
               id_d    = win_id;
            end
         end
         REQUEST: begin
            if (irq_claim)                state_d = IN_SERVICE;
            else if (!req_wide[irq_id_q]) state_d = IDLE;
         end
         IN_SERVICE: begin
            if (irq_complete) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         irq_q    <= 1'b0;
         irq_id_q <= '0;
      end else begin
         state_q  <= state_d;
         irq_q    <= (state_d == REQUEST);
         irq_id_q <= id_d;
      end
   end

   assign irq    = irq_q;
   assign irq_id = irq_id_q;

   always_comb begin
      reg_rdata = '0;
      case (reg_addr)
         ADDR_ENABLE:  reg_rdata[NUM_SOURCES-1:0] = en_q;
         ADDR_MODE:    reg_rdata[NUM_SOURCES-1:0] = mode_q;
         ADDR_PENDING: reg_rdata[NUM_SOURCES-1:0] = pend_q;
         ADDR_STATUS: begin
            reg_rdata[0]   = (state_q == IN_SERVICE);
            reg_rdata[1]   = irq_q;
            reg_rdata[7:4] = irq_id_q;
         end
         default: reg_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_ext_irq_controller.sv
// tb/tb_ext_irq_controller.sv - directed self-checking bench for ext_irq_controller
module tb_ext_irq_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  int_ext;
   logic        reg_we;
   logic [1:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic [31:0] reg_rdata;
   logic        irq;
   logic [3:0]  irq_id;
   logic        irq_claim;
   logic        irq_complete;

   int tests_run = 0;
   int tests_failed = 0;

   ext_irq_controller #(.NUM_SOURCES(2), .SYNC_STAGES(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .int_ext      (int_ext),
      .reg_we       (reg_we),
      .reg_addr     (reg_addr),
      .reg_wdata    (reg_wdata),
      .reg_rdata    (reg_rdata),
      .irq          (irq),
      .irq_id       (irq_id),
      .irq_claim    (irq_claim),
      .irq_complete (irq_complete)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [1:0] addr, input logic [31:0] data);
      reg_we    = 1'b1;
      reg_addr  = addr;
      reg_wdata = data;
      tick();
      reg_we    = 1'b0;
      reg_wdata = '0;
   endtask

   task automatic rd(input logic [1:0] addr, output logic [31:0] data);
      reg_addr = addr;
      #1;
      data = reg_rdata;
   endtask

   task automatic pulse_claim();
      irq_claim = 1'b1;
      tick();
      irq_claim = 1'b0;
   endtask

   task automatic pulse_complete();
      irq_complete = 1'b1;
      tick();
      irq_complete = 1'b0;
   endtask

   logic [31:0] v;

   initial begin
      reset = 1'b1; int_ext = 2'b00; reg_we = 1'b0; reg_addr = 2'd0;
      reg_wdata = '0; irq_claim = 1'b0; irq_complete = 1'b0;
      tick(2);
      reset = 1'b0;

      // 1: reset state, single edge source latency and claim/complete
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_id", 32'(irq_id), 32'd0);
      rd(2'd0, v); check("rst_enable", v, 32'h0);
      rd(2'd1, v); check("rst_mode", v, 32'h0);
      rd(2'd2, v); check("rst_pending", v, 32'h0);
      tick();
      rd(2'd3, v); check("rst_status", v, 32'h0);
      wr(2'd0, 32'h1);
      wr(2'd1, 32'h1);
      int_ext = 2'b01;
      tick(3);
      rd(2'd2, v); check("t1_pend_n2", v, 32'h1);
      check("t1_irq_n2", 32'(irq), 32'd0);
      tick();
      check("t1_irq_n3", 32'(irq), 32'd1);
      check("t1_id_n3", 32'(irq_id), 32'd0);
      pulse_claim();
      check("t1_irq_claim", 32'(irq), 32'd0);
      rd(2'd2, v); check("t1_pend_claim", v, 32'h0);
      rd(2'd3, v); check("t1_status_insvc", v, 32'h01);
      pulse_complete();
      rd(2'd3, v); check("t1_status_done", v, 32'h00);
      int_ext = 2'b00;
      tick(3);

      // 2: simultaneous edges, priority and follow-on request
      wr(2'd0, 32'h3);
      wr(2'd1, 32'h3);
      int_ext = 2'b11;
      tick(4);
      check("t2_irq", 32'(irq), 32'd1);
      check("t2_id0", 32'(irq_id), 32'd0);
      rd(2'd2, v); check("t2_pend_both", v, 32'h3);
      pulse_claim();
      rd(2'd2, v); check("t2_pend_after_claim", v, 32'h2);
      pulse_complete();
      check("t2_irq_idle", 32'(irq), 32'd0);
      tick();
      check("t2_irq_src1", 32'(irq), 32'd1);
      check("t2_id1", 32'(irq_id), 32'd1);
      rd(2'd2, v); check("t2_pend_src1", v, 32'h2);
      pulse_claim();
      rd(2'd2, v); check("t2_pend_clear", v, 32'h0);
      rd(2'd3, v); check("t2_status_id1", v, 32'h11);
      pulse_complete();
      int_ext = 2'b00;
      tick(3);

      // 3: level source re-entry and withdrawal
      wr(2'd1, 32'h0);
      wr(2'd0, 32'h1);
      int_ext = 2'b01;
      tick(4);
      check("t3_irq", 32'(irq), 32'd1);
      pulse_claim();
      check("t3_irq_claim", 32'(irq), 32'd0);
      rd(2'd2, v); check("t3_pend_level", v, 32'h1);
      pulse_complete();
      check("t3_irq_at_complete", 32'(irq), 32'd0);
      tick();
      check("t3_irq_reentry", 32'(irq), 32'd1);
      check("t3_id_reentry", 32'(irq_id), 32'd0);
      int_ext = 2'b00;
      tick(3);
      check("t3_irq_before_drop", 32'(irq), 32'd1);
      tick();
      check("t3_irq_dropped", 32'(irq), 32'd0);
      tick(2);

      // 4: W1C withdraws a request; a coincident new edge wins
      wr(2'd1, 32'h1);
      int_ext = 2'b01;
      tick(4);
      check("t4_irq", 32'(irq), 32'd1);
      wr(2'd2, 32'h1);
      rd(2'd2, v); check("t4_pend_w1c", v, 32'h0);
      tick();
      check("t4_irq_withdrawn", 32'(irq), 32'd0);
      int_ext = 2'b00;
      tick(3);
      int_ext = 2'b01;
      tick(4);
      check("t4_irq_again", 32'(irq), 32'd1);
      int_ext = 2'b00;
      tick();
      int_ext = 2'b01;
      tick(2);
      wr(2'd2, 32'h1);
      rd(2'd2, v); check("t4_pend_set_wins", v, 32'h1);
      tick();
      check("t4_irq_stays", 32'(irq), 32'd1);
      pulse_claim();
      pulse_complete();
      int_ext = 2'b00;
      tick(3);

      // 5: dropped disabled edge, ignored claim/complete
      wr(2'd0, 32'h0);
      wr(2'd1, 32'h2);
      int_ext = 2'b10;
      tick(4);
      wr(2'd0, 32'h2);
      tick(2);
      rd(2'd2, v); check("t5_pend_dropped", v, 32'h0);
      check("t5_irq_none", 32'(irq), 32'd0);
      pulse_claim();
      rd(2'd3, v); check("t5_claim_idle", v, 32'h00);
      int_ext = 2'b00;
      tick(3);
      int_ext = 2'b10;
      tick(4);
      check("t5_irq_src1", 32'(irq), 32'd1);
      check("t5_id_src1", 32'(irq_id), 32'd1);
      pulse_complete();
      rd(2'd3, v); check("t5_complete_request", v, 32'h12);

      // 6: claim+complete together, then reset while in service
      irq_claim = 1'b1; irq_complete = 1'b1;
      tick();
      irq_claim = 1'b0; irq_complete = 1'b0;
      rd(2'd3, v); check("t6_both_is_claim", v, 32'h11);
      int_ext = 2'b00;
      tick(3);
      int_ext = 2'b11;
      tick(3);
      rd(2'd2, v); check("t6_pend_insvc", v, 32'h2);
      rd(2'd3, v); check("t6_status_insvc", v, 32'h11);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t6_irq_reset", 32'(irq), 32'd0);
      check("t6_id_reset", 32'(irq_id), 32'd0);
      rd(2'd0, v); check("t6_enable_reset", v, 32'h0);
      rd(2'd1, v); check("t6_mode_reset", v, 32'h0);
      rd(2'd2, v); check("t6_pend_reset", v, 32'h0);
      tick();
      rd(2'd3, v); check("t6_status_reset", v, 32'h0);
      tick(5);
      check("t6_irq_disabled", 32'(irq), 32'd0);
      rd(2'd2, v); check("t6_pend_disabled", v, 32'h0);
      wr(2'd0, 32'h3);
      tick(2);
      check("t6_irq_enabled", 32'(irq), 32'd1);
      check("t6_id_enabled", 32'(irq_id), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/ext_irq_controller.md
Name: ext_irq_controller

Overview:
Receiving end of the int_ext1/int_ext2 lines that the board top level drives into the microcontroller. Synchronises the raw external interrupt pins and detects edges or levels per source. Holds per-source pending state and presents one prioritised request to the CPU core through a claim/complete handshake. Software configures it through a small word-addressed register port on the peripheral bus.

Parameters:
NUM_SOURCES, 2, number of external interrupt inputs (1..16)
SYNC_STAGES, 2, flip-flop stages in each input synchroniser (>=2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
int_ext  input  NUM_SOURCES  raw external interrupt pins, asynchronous to clk; bit 0 = int_ext1
reg_we  input  1  register write strobe, one cycle
reg_addr  input  2  register select: 0 ENABLE, 1 MODE, 2 PENDING, 3 STATUS
reg_wdata  input  32  write data; bits above NUM_SOURCES ignored
reg_rdata  output  32  combinational read data for reg_addr; unused bits read 0
irq  output  1  interrupt request to CPU, registered
irq_id  output  4  index of requested or in-service source, registered
irq_claim  input  1  one-cycle pulse: CPU accepts the current request
irq_complete  input  1  one-cycle pulse: CPU handler finished

Behaviour:
- Reset (synchronous, active-high):
  - ENABLE=0, MODE=0, PENDING=0, sync/history flops=0.
  - FSM=IDLE, irq=0, irq_id=0.
- Sync: each pin passes through SYNC_STAGES flops. Edge history flop updates every cycle, independent of enable.
- MODE bit 1 (rising-edge source):
  - PENDING[i] sets on synced 0->1 while ENABLE[i]=1. It stays set until claimed or cleared by W1C.
  - Edges while disabled are dropped.
- MODE bit 0 (level source): PENDING[i] = synced[i] & ENABLE[i] each cycle. Claim and W1C have no effect on it.
- Registers:
  - ENABLE and MODE are read/write.
  - PENDING reads the pending vector. A write clears bits where reg_wdata=1 (W1C).
  - STATUS is read-only: bit0 = in_service, bits[7:4] = irq_id, bit1 = irq.
  - A write takes effect on the next edge.
- Priority: lowest index among PENDING&ENABLE wins.
- FSM:
  - IDLE: if any PENDING&ENABLE, go to REQUEST; latch irq_id = winner, irq<=1.
  - REQUEST: irq=1, irq_id held stable.
    - irq_claim: go to IN_SERVICE, irq<=0, clear PENDING[irq_id] (edge mode only).
    - Else, if PENDING[irq_id]&ENABLE[irq_id] is 0: go to IDLE, irq<=0 (request withdrawn).
    - A higher-priority source arriving in REQUEST does not preempt; irq_id is not re-evaluated.
  - IN_SERVICE: irq=0, irq_id held. irq_complete goes to IDLE. No nesting.
- Latency, edge mode: pin stable high before edge N (SYNC_STAGES=2):
  - synced high after edge N+1
  - PENDING set at edge N+2
  - irq=1 after edge N+3
- Ignored inputs:
  - irq_claim outside REQUEST.
  - irq_complete outside IN_SERVICE.
  - Both asserted together in REQUEST: treated as claim only.
- Same-cycle conflicts on one PENDING bit: a set (new edge) wins over claim-clear and over W1C.
- Re-entry: a level source still active at complete is re-requested from IDLE. Earliest irq is one cycle after the complete edge.
- Reset mid-operation clears all state, including in-service. irq is 0 in the cycle after the reset edge.

Decomposition:
- Shared package ext_irq_pkg:
  - FSM state enum (IDLE, REQUEST, IN_SERVICE)
  - register address constants (ADDR_ENABLE=0, ADDR_MODE=1, ADDR_PENDING=2, ADDR_STATUS=3)
  - IRQ_ID_W=4
- One sub-module, irq_sync_edge:
  - per-source SYNC_STAGES synchroniser plus history flop
  - outputs synced level and a one-cycle rising pulse
  - instantiated NUM_SOURCES times
- Priority encoder, registers and FSM stay in the top module.

Test Plan:
1. Reset, ENABLE=0b01, MODE=0b01, raise int_ext[0] before edge N -> PENDING=0b01 at N+2, irq=1 and irq_id=0 after N+3; claim -> irq=0, PENDING=0, STATUS bit0=1; complete -> STATUS=0.
2. ENABLE=0b11, MODE=0b11, rising edges on both pins in the same cycle -> irq_id=0. Claim and complete -> irq_id=1 requested one cycle later, PENDING=0b10 until claimed.
3. ENABLE=0b01, MODE=0b00 (level), hold int_ext[0]=1 through claim and complete -> irq reasserts, earliest one cycle after complete. Drop the pin while in REQUEST -> irq=0 within 2 cycles of synced low.
4. Edge mode, PENDING[0]=1 in REQUEST; W1C 0x1 -> FSM returns to IDLE, irq=0 next cycle. Repeat with a new synced edge in the same cycle as W1C -> PENDING stays 1, irq stays 1.
5. Edge on int_ext[1] while ENABLE[1]=0, then set ENABLE=0b10 -> PENDING stays 0, no irq. Claim pulse in IDLE and complete pulse in REQUEST -> no state change.
6. Assert reset while IN_SERVICE with PENDING=0b10 -> after the reset edge irq=0, irq_id=0, all registers read 0. Pins held high give no request until ENABLE is written.
